// File: rtl/afe_pkg.sv
// Shared SPI frame layout, FSM encoding and sizing helper for the AFE control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package afe_pkg;

    localparam int FRAME_W  = 16;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int RNW_BIT  = FRAME_W - 1;
    localparam logic [FRAME_W-1:0] INIT_TERM = 16'hFFFF;

    // One SPI frame as it goes on the wire, MSB first.
    typedef struct packed {
        logic              rnw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } spi_frame_t;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_WAKE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_IDLE
    } afe_state_e;

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/afe_init_rom.sv
// AFE power-up register table, one 16-bit frame word per index; 0xFFFF ends the table early.
// Latency: combinational read.
// Backpressure: none.
// Ports: idx (table index), word (frame sent verbatim).
module afe_init_rom
    import afe_pkg::*;
#(
    parameter  int INIT_LEN = 16,
    localparam int IW       = cnt_w(INIT_LEN)
) (
    input  logic [IW-1:0]      idx,
    output logic [FRAME_W-1:0] word
);

    always_comb begin
        word = INIT_TERM;
        if (int'(idx) < INIT_LEN) begin
            case (idx)
                IW'(0):  word = 16'h0102;
                IW'(1):  word = 16'h0304;
                IW'(2):  word = 16'h8510;
                default: word = INIT_TERM;
            endcase
        end
    end

endmodule

// File: rtl/afe_spi_ctrl.sv
// AFE power-up sequencer (hard reset, wake wait, init table replay) and runtime SPI register master.
// Latency: host access = 1 + 16*2*CLK_DIV + CLK_DIV cycles to host_ack, then GAP_CYCLES before next frame.
// Backpressure: host_req is held until the one-cycle host_ack; requests wait while init or restart runs.
// Ports: clk/reset_n; host_req/rnw/addr/wdata -> host_ack/rdata; restart_init; rx/tx_en_req;
//        busy/init_done status; afe_reset, afe_rx_en, afe_tx_en, 4-wire SPI (sclk, sen_n, sdio, sdo).
module afe_spi_ctrl
    import afe_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int RST_CYCLES  = 1000,
    parameter int WAKE_CYCLES = 10000,
    parameter int GAP_CYCLES  = 8,
    parameter int INIT_LEN    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_req,
    input  logic              host_rnw,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              restart_init,
    input  logic              rx_en_req,
    input  logic              tx_en_req,
    output logic              busy,
    output logic              init_done,
    output logic              afe_reset,
    output logic              afe_rx_en,
    output logic              afe_tx_en,
    output logic              afe_sclk,
    output logic              afe_sen_n,
    output logic              afe_sdio,
    input  logic              afe_sdo
);

    localparam int MAX_WAIT = (RST_CYCLES > WAKE_CYCLES) ?
                              ((RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES) :
                              ((WAKE_CYCLES > GAP_CYCLES) ? WAKE_CYCLES : GAP_CYCLES);
    localparam int CW = cnt_w(MAX_WAIT);
    localparam int DW = cnt_w(CLK_DIV);
    localparam int IW = cnt_w(INIT_LEN);

    afe_state_e         state;
    logic [CW-1:0]      cnt;
    logic [DW-1:0]      div_cnt;
    logic [4:0]         bit_cnt;
    logic [FRAME_W-1:0] shreg;
    logic [DATA_W-1:0]  rx_sh;
    logic [IW-1:0]      idx;
    logic               frm_rd;
    logic               frm_host;
    logic               restart_pend;

    logic [FRAME_W-1:0] rom_word;
    spi_frame_t         host_frm;
    logic [FRAME_W-1:0] start_word;
    logic               frame_start;

    afe_init_rom #(.INIT_LEN(INIT_LEN)) u_rom (
        .idx  (idx),
        .word (rom_word)
    );

    // Reads put zeros in the data byte; the AFE answers on sdo during those bits.
    always_comb begin
        host_frm.rnw  = host_rnw;
        host_frm.addr = host_addr;
        host_frm.data = host_rnw ? '0 : host_wdata;
        start_word    = (state == ST_IDLE) ? host_frm : rom_word;
        // A pending restart always beats a host request in IDLE.
        frame_start   = ((state == ST_LOAD) && (rom_word != INIT_TERM)) ||
                        ((state == ST_IDLE) && !restart_pend && !restart_init && host_req);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RST_HOLD;
            cnt          <= '0;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_sh        <= '0;
            idx          <= '0;
            frm_rd       <= 1'b0;
            frm_host     <= 1'b0;
            restart_pend <= 1'b0;
            host_ack     <= 1'b0;
            host_rdata   <= '0;
            busy         <= 1'b1;
            init_done    <= 1'b0;
            afe_reset    <= 1'b1;
            afe_rx_en    <= 1'b0;
            afe_tx_en    <= 1'b0;
            afe_sclk     <= 1'b0;
            afe_sen_n    <= 1'b1;
            afe_sdio     <= 1'b0;
        end else begin
            host_ack  <= 1'b0;
            afe_rx_en <= rx_en_req & init_done;
            afe_tx_en <= tx_en_req & init_done;
            if (restart_init) begin
                restart_pend <= 1'b1;
            end

            case (state)
                ST_RST_HOLD: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        cnt       <= '0;
                        afe_reset <= 1'b0;
                        state     <= ST_WAKE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAKE: begin
                    if (cnt == CW'(WAKE_CYCLES - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= ST_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Non-terminator words are launched by the frame_start block below.
                    if (rom_word == INIT_TERM) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt != DW'(CLK_DIV - 1)) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (afe_sclk) begin
                            // Falling edge: present the next bit (zeros once the word is out).
                            afe_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                            afe_sdio <= shreg[FRAME_W-2];
                            shreg    <= {shreg[FRAME_W-2:0], 1'b0};
                        end else if (bit_cnt == 5'(FRAME_W)) begin
                            // Trailing low half-period done: close the frame.
                            afe_sen_n <= 1'b1;
                            afe_sdio  <= 1'b0;
                            state     <= ST_GAP;
                            cnt       <= '0;
                            if (frm_host) begin
                                host_ack <= 1'b1;
                                if (frm_rd) begin
                                    host_rdata <= rx_sh;
                                end
                            end
                        end else begin
                            afe_sclk <= 1'b1;
                            if (frm_rd && (bit_cnt >= 5'(FRAME_W - DATA_W))) begin
                                rx_sh <= {rx_sh[DATA_W-2:0], afe_sdo};
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (frm_host || (idx == IW'(INIT_LEN - 1))) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            if (!frm_host) begin
                                init_done <= 1'b1;
                            end
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LOAD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (restart_pend || restart_init) begin
                        state        <= ST_RST_HOLD;
                        cnt          <= '0;
                        busy         <= 1'b1;
                        afe_reset    <= 1'b1;
                        init_done    <= 1'b0;
                        restart_pend <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RST_HOLD;
                end
            endcase

            if (frame_start) begin
                state    <= ST_SHIFT;
                busy     <= 1'b1;
                afe_sen_n <= 1'b0;
                afe_sdio <= start_word[FRAME_W-1];
                shreg    <= start_word;
                frm_rd   <= start_word[RNW_BIT];
                frm_host <= (state == ST_IDLE);
                div_cnt  <= '0;
                bit_cnt  <= '0;
                afe_sclk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_afe_spi_ctrl.sv
module tb_afe_spi_ctrl;

    localparam int CLK_DIV     = 2;
    localparam int RST_CYCLES  = 4;
    localparam int WAKE_CYCLES = 8;
    localparam int GAP_CYCLES  = 3;
    localparam int INIT_LEN    = 16;
    localparam int CLK_T       = 10;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       host_req;
    logic       host_rnw;
    logic [6:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       restart_init;
    logic       rx_en_req;
    logic       tx_en_req;
    logic       busy;
    logic       init_done;
    logic       afe_reset;
    logic       afe_rx_en;
    logic       afe_tx_en;
    logic       afe_sclk;
    logic       afe_sen_n;
    logic       afe_sdio;
    logic       afe_sdo = 1'b0;

    int checks = 0;
    int errors = 0;

    afe_spi_ctrl #(
        .CLK_DIV(CLK_DIV), .RST_CYCLES(RST_CYCLES), .WAKE_CYCLES(WAKE_CYCLES),
        .GAP_CYCLES(GAP_CYCLES), .INIT_LEN(INIT_LEN)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .host_req(host_req), .host_rnw(host_rnw), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .restart_init(restart_init), .rx_en_req(rx_en_req), .tx_en_req(tx_en_req),
        .busy(busy), .init_done(init_done), .afe_reset(afe_reset),
        .afe_rx_en(afe_rx_en), .afe_tx_en(afe_tx_en), .afe_sclk(afe_sclk),
        .afe_sen_n(afe_sen_n), .afe_sdio(afe_sdio), .afe_sdo(afe_sdo)
    );

    always #(CLK_T / 2) clk = ~clk;

    // ---------------- AFE device model / SPI frame monitor ----------------
    function automatic logic [7:0] afe_dflt(input logic [6:0] a);
        return (a == 7'h05) ? 8'h3C : ({1'b0, a} ^ 8'hC3);
    endfunction

    logic [15:0] mon_sh = '0;
    int          mon_nrise = 0;
    int          gap_viol = 0;
    time         t_rise = 0;
    bit          t_valid = 1'b0;
    logic [15:0] frm_q[$];
    int          rise_q[$];
    logic [7:0]  dev_mem[128];
    bit          dev_vld[128];
    logic        rd_flag = 1'b0;
    logic [7:0]  rd_data = '0;

    // Slave samples sdio on SCLK rise; a chip-select fall starts a new frame.
    always @(posedge afe_sclk or negedge afe_sen_n) begin
        if (afe_sclk !== 1'b1) begin
            if (t_valid && (($time - t_rise) < GAP_CYCLES * CLK_T)) gap_viol++;
            mon_sh    = '0;
            mon_nrise = 0;
        end else if (afe_sen_n === 1'b0) begin
            mon_sh = {mon_sh[14:0], afe_sdio};
            mon_nrise++;
        end
    end

    // Read data goes out on SCLK falls after the 8 command bits.
    always @(negedge afe_sclk) begin
        if (afe_sen_n === 1'b0) begin
            if (mon_nrise == 8) begin
                rd_flag = mon_sh[7];
                rd_data = dev_vld[mon_sh[6:0]] ? dev_mem[mon_sh[6:0]] : afe_dflt(mon_sh[6:0]);
            end
            if (mon_nrise >= 8 && mon_nrise <= 15 && rd_flag) afe_sdo = rd_data[15 - mon_nrise];
            else afe_sdo = 1'b0;
        end
    end

    always @(posedge afe_sen_n) begin
        frm_q.push_back(mon_sh);
        rise_q.push_back(mon_nrise);
        if (mon_nrise == 16 && !mon_sh[15]) begin
            dev_mem[mon_sh[14:8]] = mon_sh[7:0];
            dev_vld[mon_sh[14:8]] = 1'b1;
        end
        t_rise  = $time;
        t_valid = 1'b1;
    end

    // ---------------- reference expectations ----------------
    logic [15:0] init_tbl[3] = '{16'h0102, 16'h0304, 16'h8510};
    logic [7:0]  exp_mem[128];
    logic [7:0]  last_rd = '0;
    int          frm_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp);
        chk({tag, "_present"}, 32'(frm_q.size() > frm_ptr), 1);
        if (frm_q.size() > frm_ptr) begin
            chk({tag, "_word"}, frm_q[frm_ptr], exp);
            chk({tag, "_sclk_rises"}, rise_q[frm_ptr], 16);
            frm_ptr++;
        end
    endtask

    task automatic wait_init(input string tag);
        int cyc = 0, acks = 0, en_bad = 0;
        while (init_done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (host_ack === 1'b1) acks++;
            if (((afe_rx_en | afe_tx_en) === 1'b1) && init_done !== 1'b1) en_bad++;
        end
        chk({tag, "_init_done"}, init_done, 1);
        chk({tag, "_ack_during_init"}, acks, 0);
        chk({tag, "_en_before_init"}, en_bad, 0);
        chk({tag, "_busy_at_init_done"}, busy, 0);
        chk({tag, "_init_frames"}, frm_q.size() - frm_ptr, 3);
        for (int i = 0; i < 3; i++) check_frame({tag, "_init"}, init_tbl[i]);
        frm_ptr = frm_q.size();
        for (int i = 0; i < 3; i++) if (!init_tbl[i][15]) exp_mem[init_tbl[i][14:8]] = init_tbl[i][7:0];
        chk({tag, "_en_same_cycle"}, {afe_rx_en, afe_tx_en}, 2'b00);
        @(negedge clk);
        chk({tag, "_en_next_cycle"}, {afe_rx_en, afe_tx_en}, 2'b11);
    endtask

    // Host request already raised by the caller; waits for ack and the return to idle.
    task automatic finish_access(input string tag, input logic rnw, input logic [6:0] a, input logic [7:0] d);
        int cyc = 0, acks = 0;
        while (host_ack !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        chk({tag, "_ack"}, host_ack, 1);
        chk({tag, "_sen_n_at_ack"}, afe_sen_n, 1);
        chk({tag, "_busy_at_ack"}, busy, 1);
        if (rnw) last_rd = exp_mem[a];
        else     exp_mem[a] = d;
        chk({tag, "_rdata"}, host_rdata, last_rd);
        host_req = 1'b0;
        check_frame(tag, {rnw, a, rnw ? 8'h00 : d});
        frm_ptr = frm_q.size();
        cyc = 0;
        while (busy !== 1'b0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (host_ack === 1'b1) acks++;
        end
        chk({tag, "_back_idle"}, busy, 0);
        chk({tag, "_single_ack"}, acks, 0);
    endtask

    task automatic wait_mid_frame(input int nrise);
        int cyc = 0;
        while (!(afe_sen_n === 1'b0 && mon_nrise >= nrise) && cyc < 300) begin @(negedge clk); cyc++; end
        chk("mid_frame_reached", 32'(mon_nrise >= nrise), 1);
    endtask

    task automatic count_reset_hold(input string tag);
        int n = 0;
        while (afe_reset === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk(tag, n, RST_CYCLES);
    endtask

    initial begin
        logic       r;
        logic [6:0] a;
        logic [7:0] d;
        int         cyc;

        reset_n = 1'b0;
        host_req = 1'b1; host_rnw = 1'b0; host_addr = 7'h12; host_wdata = 8'hA5;
        restart_init = 1'b0; rx_en_req = 1'b1; tx_en_req = 1'b1;
        for (int i = 0; i < 128; i++) exp_mem[i] = afe_dflt(7'(i));
        repeat (3) @(negedge clk);

        chk("rst_afe_reset", afe_reset, 1);
        chk("rst_sen_n", afe_sen_n, 1);
        chk("rst_sclk", afe_sclk, 0);
        chk("rst_sdio", afe_sdio, 0);
        chk("rst_rx_tx_en", {afe_rx_en, afe_tx_en}, 2'b00);
        chk("rst_init_done", init_done, 0);
        chk("rst_busy", busy, 1);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_host_rdata", host_rdata, 0);

        frm_ptr = frm_q.size();
        reset_n = 1'b1;
        count_reset_hold("boot_reset_hold_cycles");
        wait_init("boot");
        chk("held_req_served_first_idle", afe_sen_n, 0);
        finish_access("held_write", 1'b0, 7'h12, 8'hA5);

        host_rnw = 1'b1; host_addr = 7'h05; host_wdata = 8'($urandom); host_req = 1'b1;
        finish_access("read_05", 1'b1, 7'h05, host_wdata);

        for (int k = 0; k < 12; k++) begin
            r = 1'($urandom_range(0, 1));
            a = 7'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            host_rnw = r; host_addr = a; host_wdata = d; host_req = 1'b1;
            finish_access("rand", r, a, d);
        end

        // restart raised mid-frame is held until the controller is idle again
        a = 7'($urandom_range(8, 15)); d = 8'($urandom_range(0, 255));
        host_rnw = 1'b0; host_addr = a; host_wdata = d; host_req = 1'b1;
        wait_mid_frame(3);
        restart_init = 1'b1;
        @(negedge clk);
        restart_init = 1'b0;
        finish_access("write_during_restart_req", 1'b0, a, d);
        cyc = 0;
        while (afe_reset !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
        chk("latched_restart_reset", afe_reset, 1);
        wait_init("restart_latched");

        // restart and host request in the same idle cycle
        host_rnw = 1'b1; host_addr = 7'h03; host_req = 1'b1; restart_init = 1'b1;
        @(negedge clk);
        restart_init = 1'b0;
        chk("simul_restart_wins_reset", afe_reset, 1);
        chk("simul_restart_wins_sen_n", afe_sen_n, 1);
        chk("simul_init_done_cleared", init_done, 0);
        chk("simul_en_still_one", {afe_rx_en, afe_tx_en}, 2'b11);
        @(negedge clk);
        chk("simul_en_dropped", {afe_rx_en, afe_tx_en}, 2'b00);
        wait_init("restart_simul");
        finish_access("read_after_restart", 1'b1, 7'h03, 8'h00);

        // async reset in the middle of a frame
        host_rnw = 1'b0; host_addr = 7'h21; host_wdata = 8'h5A; host_req = 1'b1;
        wait_mid_frame(5);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_sen_n", afe_sen_n, 1);
        chk("abort_sclk", afe_sclk, 0);
        chk("abort_afe_reset", afe_reset, 1);
        chk("abort_busy", busy, 1);
        chk("abort_init_done", init_done, 0);
        chk("abort_rdata", host_rdata, 0);
        host_req = 1'b0;
        last_rd = '0;
        @(negedge clk);
        frm_ptr = frm_q.size();
        reset_n = 1'b1;
        count_reset_hold("abort_reset_hold_cycles");
        wait_init("abort_rerun");
        host_rnw = 1'b1; host_addr = 7'h02; host_req = 1'b1;
        finish_access("read_after_abort", 1'b1, 7'h02, 8'h00);

        chk("min_gap_between_frames", gap_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
